// File: rtl/writeptr_full_ctrl.sv
// Write-domain pointer and flag controller for an asynchronous FIFO.
// Keeps the binary and Gray write pointers and derives the registered full,
// almost-full, fill-level, sticky-overflow and dropped-write-count outputs
// from the read pointer that has already been synchronised into w_clk.
module writeptr_full_ctrl #(
  parameter int A_SIZE = 4,
  parameter int OVF_CW = 8
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_inc,
  input  logic [A_SIZE:0]   rptr_sync,
  input  logic [A_SIZE:0]   w_afull_thresh,
  input  logic              w_ovf_clr,
  output logic [A_SIZE-1:0] waddr,
  output logic [A_SIZE:0]   wptr,
  output logic              wen,
  output logic              wfull,
  output logic              walmost_full,
  output logic [A_SIZE:0]   wlevel,
  output logic              wovf,
  output logic [OVF_CW-1:0] w_drop_cnt
);

  // Binary write pointer; the extra MSB is the wrap bit that tells a full
  // FIFO apart from an empty one when the address bits match.
  logic [A_SIZE:0]   wbin;

  logic [A_SIZE:0]   wbin_next;
  logic [A_SIZE:0]   wgray_next;
  logic [A_SIZE:0]   rbin;
  logic [A_SIZE:0]   lvl_next;
  logic              full_next;
  logic              afull_next;
  logic              rejected;
  logic              ovf_next;
  logic [OVF_CW-1:0] drop_next;

  // A write is accepted only while the registered full flag is low, so the
  // enable never depends combinationally on the read pointer.
  assign wen      = w_inc & ~wfull;
  assign rejected = w_inc & wfull;
  assign waddr    = wbin[A_SIZE-1:0];

  // Next pointer values, read-pointer decode and all flag predictions.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    rbin       = '0;
    ovf_next   = wovf;
    drop_next  = w_drop_cnt;

    wbin_next  = wbin + (A_SIZE+1)'(wen);
    wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int i = 0; i <= A_SIZE; i++) begin
      rbin[i] = ^(rptr_sync >> i);
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer;
    // in Gray code that means the top two bits differ and the rest match.
    full_next  = (wgray_next == {~rptr_sync[A_SIZE:A_SIZE-1], rptr_sync[A_SIZE-2:0]});

    // Level uses the delayed read pointer, so it can over-report but never under-report.
    lvl_next   = wbin_next - rbin;
    afull_next = (lvl_next >= w_afull_thresh);

    // A clear wipes prior history, but a drop in the same cycle still registers.
    if (w_ovf_clr) begin
      ovf_next  = rejected;
      drop_next = OVF_CW'(rejected);
    end else if (rejected) begin
      ovf_next  = 1'b1;
      drop_next = (&w_drop_cnt) ? w_drop_cnt : w_drop_cnt + 1'b1;
    end
  end

  // State register: pointers and all registered flags, cleared asynchronously.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
      w_drop_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= lvl_next;
      wovf         <= ovf_next;
      w_drop_cnt   <= drop_next;
    end
  end

endmodule

// File: tb/tb_writeptr_full_ctrl.sv
// Self-checking bench for writeptr_full_ctrl (A_SIZE=4, OVF_CW=8).
// The reference model tracks total accepted writes and total reads as plain
// integers; fill level is their difference and full means a level of 16.
module tb_writeptr_full_ctrl;

  localparam int A = 4;
  localparam int C = 8;
  localparam int DEPTH = 1 << A;

  logic         w_clk;
  logic         w_rst_n;
  logic         w_inc;
  logic [A:0]   rptr_sync;
  logic [A:0]   w_afull_thresh;
  logic         w_ovf_clr;
  logic [A-1:0] waddr;
  logic [A:0]   wptr;
  logic         wen;
  logic         wfull;
  logic         walmost_full;
  logic [A:0]   wlevel;
  logic         wovf;
  logic [C-1:0] w_drop_cnt;

  writeptr_full_ctrl #(.A_SIZE(A), .OVF_CW(C)) dut (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_inc          (w_inc),
    .rptr_sync      (rptr_sync),
    .w_afull_thresh (w_afull_thresh),
    .w_ovf_clr      (w_ovf_clr),
    .waddr          (waddr),
    .wptr           (wptr),
    .wen            (wen),
    .wfull          (wfull),
    .walmost_full   (walmost_full),
    .wlevel         (wlevel),
    .wovf           (wovf),
    .w_drop_cnt     (w_drop_cnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int m_wr;     // total accepted writes since reset
  int m_rd;     // total reads reflected on rptr_sync
  int m_lvl;
  int m_thresh;
  bit m_full, m_af, m_ovf;
  int m_drop;
  int wraps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A:0] to_gray(input int b);
    logic [A:0] x;
    x = b[A:0];
    return x ^ (x >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_lvl = 0;
    m_full = 0; m_af = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".waddr"},  32'(waddr),        32'(m_wr % DEPTH));
    check({ph, ".wptr"},   32'(wptr),         32'(to_gray(m_wr % (2 * DEPTH))));
    check({ph, ".wfull"},  32'(wfull),        32'(m_full));
    check({ph, ".afull"},  32'(walmost_full), 32'(m_af));
    check({ph, ".wlevel"}, 32'(wlevel),       32'(m_lvl));
    check({ph, ".wovf"},   32'(wovf),         32'(m_ovf));
    check({ph, ".drop"},   32'(w_drop_cnt),   32'(m_drop));
  endtask

  // Async reset between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    w_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    #1;
    w_rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check wen before the edge, update model, check after.
  task automatic step(input bit inc, input bit clr);
    bit acc, rej;
    logic [A:0] prev_wptr;
    logic [A-1:0] prev_addr;
    w_inc          = inc;
    w_ovf_clr      = clr;
    rptr_sync      = to_gray(m_rd % (2 * DEPTH));
    w_afull_thresh = m_thresh[A:0];
    #1;
    acc = inc && !m_full;
    rej = inc && m_full;
    check("wen", 32'(wen), 32'(acc));
    prev_wptr = wptr;
    prev_addr = waddr;
    @(posedge w_clk);
    m_wr  = m_wr + int'(acc);
    m_lvl = (m_wr - m_rd) % (2 * DEPTH);
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= m_thresh);
    if (clr) begin
      m_ovf  = rej;
      m_drop = int'(rej);
    end else if (rej) begin
      m_ovf  = 1'b1;
      m_drop = (m_drop < (1 << C) - 1) ? m_drop + 1 : m_drop;
    end
    @(negedge w_clk);
    check_outputs("post");
    if (acc) begin
      check("gray_1bit", 32'($countones(prev_wptr ^ wptr)), 32'd1);
      if (prev_addr == A'(DEPTH - 1) && waddr == '0) wraps++;
    end
  endtask

  initial begin
    w_rst_n = 1'b0; w_inc = 1'b0; w_ovf_clr = 1'b0;
    rptr_sync = '0; w_afull_thresh = '0;
    m_thresh = 12;
    model_reset();
    @(negedge w_clk);

    // 1. Fill from empty with threshold 12.
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 1'b0);
      if (k == 11) check("afull_below", 32'(walmost_full), 32'd0);
      if (k == 12) begin
        check("afull_at12", 32'(walmost_full), 32'd1);
        check("lvl_at12",   32'(wlevel),       32'd12);
      end
    end
    check("fill.wfull",  32'(wfull),  32'd1);
    check("fill.wlevel", 32'(wlevel), 32'd16);
    check("fill.wptr",   32'(wptr),   32'b11000);

    // 2. Overflow while full, then clear coinciding with another drop.
    repeat (3) step(1'b1, 1'b0);
    check("ovf.wptr", 32'(wptr),       32'b11000);
    check("ovf.flag", 32'(wovf),       32'd1);
    check("ovf.cnt",  32'(w_drop_cnt), 32'd3);
    step(1'b1, 1'b1);
    check("clr.flag", 32'(wovf),       32'd1);
    check("clr.cnt",  32'(w_drop_cnt), 32'd1);

    // 4. Release: one synced read clears full on the next edge.
    m_rd = 1;
    step(1'b0, 1'b0);
    check("rel.wfull",  32'(wfull),  32'd0);
    check("rel.wlevel", 32'(wlevel), 32'd15);
    step(1'b1, 1'b0);
    check("rel.accept", 32'(waddr),  32'd1);
    check("rel.refull", 32'(wfull),  32'd1);

    // 5. Saturation of the dropped-write counter.
    repeat (300) step(1'b1, 1'b0);
    check("sat.cnt", 32'(w_drop_cnt), 32'd255);
    step(1'b1, 1'b0);
    check("sat.hold", 32'(w_drop_cnt), 32'd255);

    // 3. Wrap: 40 writes while the reader trails a few entries behind.
    do_reset();
    m_thresh = 8;
    wraps = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_wr - m_rd > 4) m_rd++;
      step(1'b1, 1'b0);
    end
    check("wrap.count", 32'(wraps), 32'd2);
    check("wrap.nofull", 32'(wfull), 32'd0);

    // 6. Async reset mid-fill; first write afterwards goes to address 0.
    do_reset();
    repeat (7) step(1'b1, 1'b0);
    do_reset();
    check("rst.waddr0", 32'(waddr), 32'd0);
    step(1'b1, 1'b0);
    check("rst.first", 32'(waddr), 32'd1);

    // Threshold boundaries: 0 always asserts, above depth never asserts.
    m_thresh = 0;
    step(1'b0, 1'b0);
    check("thr0", 32'(walmost_full), 32'd1);
    m_thresh = 17;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
    check("thr17.full", 32'(wfull), 32'd1);
    check("thr17.af",   32'(walmost_full), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      if (($urandom % 16) == 0) m_thresh = int'($urandom_range(0, 20));
      if (m_rd < m_wr && ($urandom % 2) == 1) m_rd++;
      step(($urandom % 10) < 7, ($urandom % 20) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
